usr_reg_stage: RTL
==================

Name: usr_reg_stage

Overview:
- Storage stage of the reversible universal shift register: WIDTH D-type cells, each fed by a per-bit 4:1 select.
- Mode encoding matches the per-bit selector: mode 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- Adds rotate, a shift counter and a drained flag so downstream logic knows when every loaded bit has left the register.
- Consumes the mode/serial/parallel operands and feeds the serial and parallel outputs to the surrounding datapath.

Parameters:
- WIDTH, 4: register width in bits (min 2).
- CNT_W, 8: width of shift_cnt; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when low, all state holds.
- mode  input  2  bit1=s1, bit0=s0. 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rotate  input  1  when high, shifts recirculate (serial inputs ignored).
- sir  input  1  serial input entering the MSB on shift right.
- sil  input  1  serial input entering the LSB on shift left.
- pin  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sor  output  1  serial out right = q[0] (combinational from q).
- sol  output  1  serial out left = q[WIDTH-1] (combinational from q).
- shift_cnt  output  CNT_W  shifts since last load or reset, saturating.
- drained  output  1  registered; high when shift_cnt >= WIDTH.

Behaviour:
- Reset: rst=1 at a clock edge -> q=0, shift_cnt=0, drained=0. rst has priority over en and mode; a reset in the middle of a shift sequence discards it.
- en=0: q, shift_cnt and drained hold regardless of mode, rotate or data inputs.
- en=1, mode 00: q, shift_cnt and drained hold.
- en=1, mode 01 (shift right): q <= {din_r, q[WIDTH-1:1]}.
  - din_r = q[0] if rotate=1, else sir.
- en=1, mode 10 (shift left): q <= {q[WIDTH-2:0], din_l}.
  - din_l = q[WIDTH-1] if rotate=1, else sil.
- en=1, mode 11 (parallel load): q <= pin; shift_cnt <= 0; drained <= 0. rotate is ignored.
- Shift counter: each enabled shift (mode 01 or 10) increments shift_cnt by 1. At 2^CNT_W-1 it stays there (no wrap).
- Direction changes do not reset the counter; only a load or reset clears it.
- drained is updated in the same cycle as shift_cnt, from the next-state count. Example with WIDTH=4: the 4th shift after a load sets drained=1 in the cycle where q shows the 4th shifted value.
- drained stays high through further shifts, holds and en=0 until the next load or reset. Rotate does not suppress it.
- Latency:
  - q, shift_cnt and drained change exactly one clock after the qualifying edge inputs; there is no combinational path from inputs to q.
  - sor and sol follow q combinationally.
- Simultaneous events: rst over load over shift. A load and a counter saturation never conflict because load clears the counter.
- Inputs are sampled only at the clock edge; glitches between edges have no effect.

Test Plan:
- Reset then load: rst=1 for one edge, then en=1, mode=11, pin=4'b1011 -> q=1011, shift_cnt=0, drained=0, sor=1, sol=1.
- Shift right: from q=1011, mode=01, sir=0, rotate=0, 4 edges -> q=0101, 0010, 0001, 0000. shift_cnt reaches 4; drained rises on the 4th edge; sor sequence 1,1,0,1 before each edge.
- Shift left with rotate: load 1000, mode=10, rotate=1, sil=0, 4 edges -> q=0001, 0010, 0100, 1000 (original restored). drained=1 after the 4th edge.
- Hold and enable gating: q=0110, toggle mode and data with en=0 for 3 edges, then en=1, mode=00 for 2 edges -> q=0110 and shift_cnt unchanged throughout.
- Saturation and mid-operation reset: CNT_W=3, 9 enabled shifts -> shift_cnt sticks at 7 and drained=1. Assert rst during a shift -> q=0, shift_cnt=0, drained=0 on that edge.
- Priority: on the same edge rst=1 and mode=11 with pin=1111 -> q=0. The next edge with rst=0 and mode=11 -> q=1111, shift_cnt=0.

Source files
------------

// File: rtl/usr_reg_stage.sv
// Storage stage of the reversible universal shift register.
// Per-bit 4:1 select with rotate, saturating shift counter and drained flag.
module usr_reg_stage #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             rotate,
   input  logic             sir,
   input  logic             sil,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] q,
   output logic             sor,
   output logic             sol,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             drained
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [31:0]      W32     = WIDTH;

   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drained_q, drained_d;
   logic             din_r, din_l;
   logic             shift;

   assign din_r = rotate ? data_q[0] : sir;
   assign din_l = rotate ? data_q[WIDTH-1] : sil;
   assign shift = en && (mode == 2'b01 || mode == 2'b10);

   always_comb begin
      data_d = data_q;
      if (en) begin
         unique case (mode)
            2'b00: data_d = data_q;
            2'b01: data_d = {din_r, data_q[WIDTH-1:1]};
            2'b10: data_d = {data_q[WIDTH-2:0], din_l};
            2'b11: data_d = pin;
            default: data_d = data_q;
         endcase
      end
   end

   // counter saturates; a load clears both counter and flag
   always_comb begin
      cnt_d     = cnt_q;
      drained_d = drained_q;
      if (en && mode == 2'b11) begin
         cnt_d     = '0;
         drained_d = 1'b0;
      end else if (shift) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
         drained_d = drained_q | (32'(cnt_d) >= W32);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         cnt_q     <= '0;
         drained_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         drained_q <= drained_d;
      end
   end

   assign q         = data_q;
   assign sor       = data_q[0];
   assign sol       = data_q[WIDTH-1];
   assign shift_cnt = cnt_q;
   assign drained   = drained_q;

endmodule
